patterner_cell_p: RTL

- Parametrised next-generation muon pattern cell for one key wire group of the ALCT pattern-finder array.
- Each clock it counts the layers with a hit inside two programmable masks: a collision mask and an accelerator mask.
- Each pattern runs a saturating BX counter and declares a valid pattern at the configured drift time if the hit count meets threshold.
- Also provides registered outputs, peak-hold quality over the drift window, a programmable post-trigger dead time, and the four trig_mode kill rules; one instance per key wire group, feeding the best-track sorter.

---
 rtl/patterner_pkg.sv | 30 +++
 rtl/patterner_cell_p_if.sv | 38 +++
 rtl/patterner_chan.sv | 73 +++++++
 rtl/patterner_cell_p.sv | 78 +++++++
 4 files changed

// File: rtl/patterner_pkg.sv
// Shared definitions for the pattern cell: trigger-mode encodings,
// the layer-count helper and the saturating quality function.
package patterner_pkg;

    typedef enum logic [1:0] {
        TM_BOTH      = 2'd0,
        TM_KILL_COLL = 2'd1,
        TM_KILL_ACC  = 2'd2,
        TM_ACC_VETO  = 2'd3
    } trig_mode_t;

    function automatic int layer_count(input logic [31:0] hits);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(hits[i]);
        end
        return n;
    endfunction

    // Offset-subtracted layer count, floored at 0 and clipped to the output width.
    function automatic int sat_quality(input int qv, input int qofs, input int qw);
        int q;
        int qmax;
        q    = (qv >= qofs) ? (qv - qofs) : 0;
        qmax = (1 << qw) - 1;
        return (q > qmax) ? qmax : q;
    endfunction

endpackage

// File: rtl/patterner_cell_p_if.sv
// Hit, mask, configuration and result bundle for one pattern cell.
interface patterner_cell_p_if #(
    parameter int NLY  = 6,
    parameter int WIN  = 3,
    parameter int CNTW = 3,
    parameter int QW   = 2,
    parameter int DTW  = 4
);
    localparam int SW = $clog2(NLY + 1);

    logic [NLY*WIN-1:0] ly;
    logic [NLY*WIN-1:0] collmask;
    logic [NLY*WIN-1:0] accmask;
    logic [CNTW-1:0]    drifttime;
    logic [SW-1:0]      pretrig;
    logic [SW-1:0]      trig;
    logic [SW-1:0]      acc_pretrig;
    logic [SW-1:0]      acc_trig;
    logic [DTW-1:0]     deadtime;
    logic [1:0]         trig_mode;
    logic               vc;
    logic [QW-1:0]      qc;
    logic               va;
    logic [QW-1:0]      qa;

    modport master (
        output ly, collmask, accmask, drifttime, pretrig, trig,
               acc_pretrig, acc_trig, deadtime, trig_mode,
        input  vc, qc, va, qa
    );

    modport slave (
        input  ly, collmask, accmask, drifttime, pretrig, trig,
               acc_pretrig, acc_trig, deadtime, trig_mode,
        output vc, qc, va, qa
    );

endinterface

// File: rtl/patterner_chan.sv
// One pattern channel: masked layer count, saturating BX counter, peak hold,
// dead time and quality. The caller supplies kill and veto terms.
module patterner_chan
    import patterner_pkg::*;
#(
    parameter int NLY  = 6,
    parameter int WIN  = 3,
    parameter int CNTW = 3,
    parameter int QW   = 2,
    parameter int QOFS = 3,
    parameter int DTW  = 4,
    localparam int SW  = $clog2(NLY + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NLY*WIN-1:0] ly,
    input  logic [NLY*WIN-1:0] mask,
    input  logic [CNTW-1:0]    drifttime,
    input  logic [SW-1:0]      pretrig,
    input  logic [SW-1:0]      trig,
    input  logic [DTW-1:0]     deadtime,
    input  logic               kill,
    input  logic               veto,
    output logic               fire,
    output logic [QW-1:0]      quality
);

    logic [NLY-1:0]  hit_ly;
    logic [SW-1:0]   sum;
    logic [SW-1:0]   qv;
    logic [CNTW-1:0] bx;
    logic [SW-1:0]   pk;
    logic [DTW-1:0]  dead;
    logic            clr;

    always_comb begin
        hit_ly = '0;
        for (int k = 0; k < NLY; k++) begin
            hit_ly[k] = |(ly[k*WIN +: WIN] & mask[k*WIN +: WIN]);
        end
    end

    assign sum     = SW'(layer_count(32'(hit_ly)));
    assign qv      = (pk > sum) ? pk : sum;
    assign quality = QW'(sat_quality(int'(qv), QOFS, QW));
    assign clr     = (sum < pretrig) | kill | (dead != '0);

    // Veto only blocks the fire; it must not arm this channel's dead time.
    assign fire = (bx == drifttime) & (sum >= trig) & (dead == '0) & ~kill & ~veto;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bx   <= '0;
            pk   <= '0;
            dead <= '0;
        end else begin
            if (clr) begin
                bx <= '0;
                pk <= '0;
            end else begin
                bx <= (bx == '1) ? bx : bx + 1'b1;
                pk <= qv;
            end

            if (fire) begin
                dead <= deadtime;
            end else if (dead != '0) begin
                dead <= dead - 1'b1;
            end
        end
    end

endmodule

// File: rtl/patterner_cell_p.sv
// Pattern cell for one key wire group: collision and accelerator channels,
// trig_mode kill/veto rules and the registered valid/quality outputs.
module patterner_cell_p
    import patterner_pkg::*;
#(
    parameter int NLY  = 6,
    parameter int WIN  = 3,
    parameter int CNTW = 3,
    parameter int QW   = 2,
    parameter int QOFS = 3,
    parameter int DTW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    patterner_cell_p_if.slave bus
);

    logic          fire_c;
    logic          fire_a;
    logic [QW-1:0] q_c;
    logic [QW-1:0] q_a;
    logic          kill_c;
    logic          kill_a;
    logic          veto_c;

    assign kill_c = (bus.trig_mode == TM_KILL_COLL);
    assign kill_a = (bus.trig_mode == TM_KILL_ACC);
    assign veto_c = (bus.trig_mode == TM_ACC_VETO) & fire_a;

    patterner_chan #(
        .NLY(NLY), .WIN(WIN), .CNTW(CNTW), .QW(QW), .QOFS(QOFS), .DTW(DTW)
    ) u_coll (
        .clk       (clk),
        .rst_n     (rst_n),
        .ly        (bus.ly),
        .mask      (bus.collmask),
        .drifttime (bus.drifttime),
        .pretrig   (bus.pretrig),
        .trig      (bus.trig),
        .deadtime  (bus.deadtime),
        .kill      (kill_c),
        .veto      (veto_c),
        .fire      (fire_c),
        .quality   (q_c)
    );

    patterner_chan #(
        .NLY(NLY), .WIN(WIN), .CNTW(CNTW), .QW(QW), .QOFS(QOFS), .DTW(DTW)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .ly        (bus.ly),
        .mask      (bus.accmask),
        .drifttime (bus.drifttime),
        .pretrig   (bus.acc_pretrig),
        .trig      (bus.acc_trig),
        .deadtime  (bus.deadtime),
        .kill      (kill_a),
        .veto      (1'b0),
        .fire      (fire_a),
        .quality   (q_a)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.vc <= 1'b0;
            bus.qc <= '0;
            bus.va <= 1'b0;
            bus.qa <= '0;
        end else begin
            bus.vc <= fire_c;
            bus.qc <= fire_c ? q_c : '0;
            bus.va <= fire_a;
            bus.qa <= fire_a ? q_a : '0;
        end
    end

endmodule
